// File: rtl/gray_count_arbiter.sv
// gray_count_arbiter: one binary/Gray counter shared by two requesters.
// Each requester asks for a burst of N increments and may clear the counter first.
// Arbitration is round-robin and happens only in IDLE.
// Each burst ends with a one-cycle done strobe tagged with the owner id.
module gray_count_arbiter #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req0_clr,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [LEN_W-1:0] req1_len,
    input  logic             req1_clr,
    output logic             req1_ready,
    output logic             busy,
    output logic             owner,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] gray_out,
    output logic             done_pulse,
    output logic             done_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    // r_prio holds the requester favoured on a tie: the one not served last.
    logic             r_prio;
    logic             w_prio_nxt;

    logic             w_idle;
    logic             w_grant_sel;
    logic             w_accept;
    logic [LEN_W-1:0] w_sel_len;
    logic             w_sel_clr;

    // Grant selection: a lone requester wins outright, and a tie goes to r_prio.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_grant_sel = r_prio;
        if (req0_valid && !req1_valid) begin
            w_grant_sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant_sel = 1'b1;
        end
    end

    assign w_idle     = (r_state == S_IDLE);
    assign req0_ready = w_idle && req0_valid && !w_grant_sel;
    assign req1_ready = w_idle && req1_valid &&  w_grant_sel;
    assign w_accept   = req0_ready || req1_ready;

    // Only the granted requester's length and clear matter.
    // The loser's clr is never looked at.
    assign w_sel_len = w_grant_sel ? req1_len : req0_len;
    assign w_sel_clr = w_grant_sel ? req1_clr : req0_clr;

    // Next-state logic: burst sequencing, counter update and arbitration bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_rem_nxt   = r_rem;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_owner_nxt = w_grant_sel;
                    w_prio_nxt  = ~w_grant_sel;
                    w_rem_nxt   = w_sel_len;
                    if (w_sel_clr) begin
                        w_bin_nxt = '0;
                    end
                    // A zero-length burst skips RUN but still produces its done strobe.
                    w_state_nxt = (w_sel_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_bin_nxt = r_bin + WIDTH'(1);
                w_rem_nxt = r_rem - LEN_W'(1);
                // The increment that takes remaining from 1 to 0 is the last one.
                if (r_rem <= LEN_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // The asynchronous reset aborts any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_rem   <= '0;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
            r_rem   <= w_rem_nxt;
            r_owner <= w_owner_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign owner      = r_owner;
    assign bin_count  = r_bin;
    assign gray_out   = r_bin ^ (r_bin >> 1);
    assign done_pulse = (r_state == S_DONE);
    assign done_id    = (r_state == S_DONE) ? r_owner : 1'b0;

endmodule
